bp_softcore_mem: RTL and testbench

Single-port, multi-cycle memory endpoint for the softcore's main-memory path. It consumes `bp_cce_mem_msg_s` commands from the softcore's `mem_cmd_o` and produces `bp_cce_mem_msg_s` responses on its `mem_resp_i`. It is the default backing store for FPGA and simulation softcore builds. It is backed by a byte-maskable synchronous RAM and serialises block accesses one dword per cycle.

---
 rtl/bp_softcore_mem_pkg.sv | 47 ++++
 rtl/bp_softcore_mem_ram.sv | 31 +++
 rtl/bp_softcore_mem.sv | 152 +++++++++++++++
 tb/tb_bp_softcore_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_softcore_mem_pkg.sv
// Softcore memory message types shared by the memory endpoint and its clients.
package bp_softcore_mem_pkg;

   localparam int paddr_width_p     = 40;
   localparam int cce_block_width_p = 512;
   localparam int lce_id_width_p    = 4;
   localparam int lce_assoc_p       = 8;
   localparam int dword_width_p     = 64;

   typedef enum logic [3:0] {
      e_cce_mem_rd    = 4'd0,
      e_cce_mem_wr    = 4'd1,
      e_cce_mem_uc_rd = 4'd2,
      e_cce_mem_uc_wr = 4'd3,
      e_cce_mem_pre   = 4'd4
   } bp_cce_mem_cmd_type_e;

   typedef enum logic [2:0] {
      e_mem_msg_size_1  = 3'd0,
      e_mem_msg_size_2  = 3'd1,
      e_mem_msg_size_4  = 3'd2,
      e_mem_msg_size_8  = 3'd3,
      e_mem_msg_size_16 = 3'd4,
      e_mem_msg_size_32 = 3'd5,
      e_mem_msg_size_64 = 3'd6
   } bp_mem_msg_size_e;

   typedef struct packed {
      logic [$clog2(lce_assoc_p)-1:0] way_id;
      logic [lce_id_width_p-1:0]      lce_id;
   } bp_cce_mem_payload_s;

   typedef struct packed {
      bp_cce_mem_payload_s        payload;
      bp_mem_msg_size_e           size;
      logic [paddr_width_p-1:0]   addr;
      bp_cce_mem_cmd_type_e       msg_type;
   } bp_cce_mem_msg_header_s;

   typedef struct packed {
      logic [cce_block_width_p-1:0] data;
      bp_cce_mem_msg_header_s       header;
   } bp_cce_mem_msg_s;

   localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bp_softcore_mem_ram.sv
// Single-port synchronous RAM with byte write mask; read data appears one cycle after v.
// No backpressure: one access per cycle, contents are never reset.
module bp_softcore_mem_ram #(
   parameter int width_p = 64,
   parameter int els_p   = 65536,
   localparam int aw_lp  = $clog2(els_p)
) (
   input  logic               i_clk,
   input  logic               i_v,
   input  logic               i_w,
   input  logic [aw_lp-1:0]   i_addr,
   input  logic [width_p-1:0] i_data,
   input  logic [width_p/8-1:0] i_mask,
   output logic [width_p-1:0] o_data
);
   logic [width_p-1:0] r_mem [els_p];
   logic [width_p-1:0] r_data;

   always_ff @(posedge i_clk) begin
      if (i_v) begin
         if (i_w) begin
            for (int b = 0; b < width_p/8; b++)
               if (i_mask[b]) r_mem[i_addr][b*8 +: 8] <= i_data[b*8 +: 8];
         end else begin
            r_data <= r_mem[i_addr];
         end
      end
   end

   assign o_data = r_data;
endmodule

// File: rtl/bp_softcore_mem.sv
// Multi-cycle memory endpoint: response valid latency_p + N + 1 cycles after accept.
// One command in flight; ready only when idle, response held until yumi.
module bp_softcore_mem
   import bp_softcore_mem_pkg::*;
#(
   parameter int          mem_els_p  = 65536,
   parameter logic [31:0] mem_base_p = 32'h8000_0000,
   parameter int          latency_p  = 0
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  bp_cce_mem_msg_s mem_cmd_i,
   input  logic            mem_cmd_v_i,
   output logic            mem_cmd_ready_o,
   output bp_cce_mem_msg_s mem_resp_o,
   output logic            mem_resp_v_o,
   input  logic            mem_resp_yumi_i
);
   localparam int aw_lp = $clog2(mem_els_p);
   localparam logic [paddr_width_p-1:0] base_lp = paddr_width_p'(mem_base_p);

   typedef enum logic [2:0] {e_reset, e_ready, e_wait, e_access, e_resp} state_e;

   function automatic logic [3:0] dword_cnt(input logic [2:0] size);
      if (size <= 3'd3)      return 4'd1;
      else if (size >= 3'd6) return 4'd8;
      else                   return 4'd1 << (size - 3'd3);
   endfunction

   // Dword j of an access, wrapping inside the size-aligned block (critical dword first)
   function automatic logic [aw_lp-1:0] dword_idx(input logic [paddr_width_p-1:0] addr,
                                                  input logic [2:0] size, input logic [2:0] j);
      logic [aw_lp-1:0] idx;
      logic [2:0]       wrap;
      idx  = aw_lp'((addr - base_lp) >> 3);
      wrap = 3'(dword_cnt(size) - 4'd1);
      return {idx[aw_lp-1:3], (idx[2:0] & ~wrap) | ((idx[2:0] + j) & wrap)};
   endfunction

   function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] off);
      case (size)
         3'd0:    return 8'h01 << off;
         3'd1:    return 8'h03 << off;
         3'd2:    return 8'h0F << off;
         default: return 8'hFF;
      endcase
   endfunction

   state_e                       r_state, w_state_n;
   bp_cce_mem_msg_header_s       r_hdr;
   logic [cce_block_width_p-1:0] r_wdata, r_rdata;
   logic [7:0]                   r_lat_cnt, r_cap_slot;
   logic [2:0]                   r_dw_cnt;
   logic                         r_issue_done, r_cap_v, r_ready, r_resp_v;
   logic                         w_accept, w_is_rd, w_is_wr, w_step, w_issue, w_sub;
   logic [2:0]                   w_off;
   logic [3:0]                   w_n;
   logic [aw_lp-1:0]             w_ram_addr;
   logic [63:0]                  w_ram_wdata, w_ram_rdata, w_sub_mask;
   logic [7:0]                   w_ram_mask;

   assign w_accept    = r_ready & mem_cmd_v_i;
   assign w_is_rd     = (r_hdr.msg_type == e_cce_mem_rd) || (r_hdr.msg_type == e_cce_mem_uc_rd);
   assign w_is_wr     = (r_hdr.msg_type == e_cce_mem_wr) || (r_hdr.msg_type == e_cce_mem_uc_wr);
   assign w_sub       = (r_hdr.size < e_mem_msg_size_8);
   assign w_off       = r_hdr.addr[2:0];
   assign w_n         = (w_is_rd || w_is_wr) ? dword_cnt(r_hdr.size) : 4'd1;
   assign w_step      = (r_state == e_access) && !r_issue_done;
   assign w_issue     = w_step && (w_is_rd || w_is_wr);
   assign w_ram_addr  = dword_idx(r_hdr.addr, r_hdr.size, r_dw_cnt);
   assign w_ram_mask  = byte_mask(r_hdr.size, w_off);
   assign w_ram_wdata = w_sub ? (r_wdata[63:0] << {w_off, 3'b000}) : r_wdata[{r_dw_cnt, 6'b0} +: 64];

   always_comb begin
      w_sub_mask = 64'hFFFF_FFFF;
      case (r_hdr.size)
         e_mem_msg_size_1: w_sub_mask = 64'hFF;
         e_mem_msg_size_2: w_sub_mask = 64'hFFFF;
         default:          w_sub_mask = 64'hFFFF_FFFF;
      endcase
   end

   bp_softcore_mem_ram #(.width_p(dword_width_p), .els_p(mem_els_p)) ram (
      .i_clk  (clk_i),
      .i_v    (w_issue),
      .i_w    (w_is_wr),
      .i_addr (w_ram_addr),
      .i_data (w_ram_wdata),
      .i_mask (w_ram_mask),
      .o_data (w_ram_rdata)
   );

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         e_reset:  w_state_n = e_ready;
         e_ready:  if (w_accept) w_state_n = (latency_p > 0) ? e_wait : e_access;
         e_wait:   if ({1'b0, r_lat_cnt} + 9'd1 >= 9'(latency_p)) w_state_n = e_access;
         e_access: if (r_issue_done) w_state_n = e_resp;
         e_resp:   if (mem_resp_yumi_i) w_state_n = e_ready;
         default:  w_state_n = e_reset;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= e_reset;
         r_ready      <= 1'b0;
         r_resp_v     <= 1'b0;
         r_hdr        <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_lat_cnt    <= '0;
         r_dw_cnt     <= '0;
         r_issue_done <= 1'b0;
         r_cap_v      <= 1'b0;
         r_cap_slot   <= '0;
      end else begin
         r_state    <= w_state_n;
         r_ready    <= (w_state_n == e_ready);
         r_resp_v   <= (w_state_n == e_resp);
         r_cap_v    <= w_issue && w_is_rd;
         r_cap_slot <= 8'd1 << r_dw_cnt;
         if (w_accept) begin
            r_hdr        <= mem_cmd_i.header;
            r_wdata      <= mem_cmd_i.data;
            r_rdata      <= '0;
            r_lat_cnt    <= '0;
            r_dw_cnt     <= '0;
            r_issue_done <= 1'b0;
         end
         if (r_state == e_wait && r_lat_cnt != 8'hFF) r_lat_cnt <= r_lat_cnt + 8'd1;
         if (w_step) begin
            if ({1'b0, r_dw_cnt} == w_n - 4'd1) r_issue_done <= 1'b1;
            else if (r_dw_cnt != 3'd7)           r_dw_cnt     <= r_dw_cnt + 3'd1;
         end
         // Read data lands one cycle after issue, into the slot of its access order
         if (r_cap_v) begin
            if (w_sub)
               r_rdata[63:0] <= (w_ram_rdata >> {w_off, 3'b000}) & w_sub_mask;
            else
               for (int k = 0; k < 8; k++)
                  if (r_cap_slot[k]) r_rdata[k*64 +: 64] <= w_ram_rdata;
         end
      end
   end

   assign mem_cmd_ready_o   = r_ready;
   assign mem_resp_v_o      = r_resp_v;
   assign mem_resp_o.header = r_hdr;
   assign mem_resp_o.data   = r_rdata;
endmodule

// File: tb/tb_bp_softcore_mem.sv
// Directed bench for bp_softcore_mem with a scoreboard and a byte-level memory model.
module tb_bp_softcore_mem;
   import bp_softcore_mem_pkg::*;
   localparam int MW = cce_mem_msg_width_lp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, cv, yv, sel;
   bp_cce_mem_msg_s cmd, resp0, resp1, resp, last_resp;
   logic            v0, v1, y0, y1, rdy0, rdy1, rv0, rv1, rdy, rv;

   assign v0   = cv & ~sel;
   assign v1   = cv & sel;
   assign y0   = yv & ~sel;
   assign y1   = yv & sel;
   assign rdy  = sel ? rdy1 : rdy0;
   assign rv   = sel ? rv1 : rv0;
   assign resp = sel ? resp1 : resp0;

   bp_softcore_mem #(.latency_p(0)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(v0), .mem_cmd_ready_o(rdy0),
      .mem_resp_o(resp0), .mem_resp_v_o(rv0), .mem_resp_yumi_i(y0));

   bp_softcore_mem #(.latency_p(4)) dut_lat (
      .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(v1), .mem_cmd_ready_o(rdy1),
      .mem_resp_o(resp1), .mem_resp_v_o(rv1), .mem_resp_yumi_i(y1));

   int vectors = 0, errors = 0;
   bp_cce_mem_msg_s sb[$];
   logic [63:0] mdl [int];

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int didx(input logic [39:0] a);
      logic [39:0] o;
      o = (a - 40'h00_8000_0000) >> 3;
      return int'(o[15:0]);
   endfunction

   function automatic int ndw(input logic [2:0] s);
      return (s <= 3'd3) ? 1 : (1 << (int'(s) - 3));
   endfunction

   function automatic int ord(input logic [39:0] a, input logic [2:0] s, input int j);
      int i, n;
      i = didx(a);
      n = ndw(s);
      return (i / n) * n + (i + j) % n;
   endfunction

   function automatic logic [511:0] mdl_read(input logic [39:0] a, input logic [2:0] s);
      logic [511:0] r;
      logic [63:0]  w;
      r = '0;
      if (s >= 3'd3) begin
         for (int j = 0; j < ndw(s); j++) r[j*64 +: 64] = mdl[ord(a, s, j)];
      end else begin
         w = mdl[didx(a)];
         for (int k = 0; k < (1 << s); k++) r[k*8 +: 8] = w[(int'(a[2:0]) + k)*8 +: 8];
      end
      return r;
   endfunction

   task automatic mdl_write(input logic [39:0] a, input logic [2:0] s, input logic [511:0] d);
      logic [63:0] w;
      int i;
      if (s >= 3'd3) begin
         for (int j = 0; j < ndw(s); j++) mdl[ord(a, s, j)] = d[j*64 +: 64];
      end else begin
         i = didx(a);
         w = mdl.exists(i) ? mdl[i] : '0;
         for (int k = 0; k < (1 << s); k++) w[(int'(a[2:0]) + k)*8 +: 8] = d[k*8 +: 8];
         mdl[i] = w;
      end
   endtask

   task automatic xact(input bp_cce_mem_cmd_type_e t, input logic [39:0] a, input logic [2:0] s,
                       input logic [511:0] d, input int hold, input string tag);
      bp_cce_mem_msg_s e, first;
      int cyc, rdy_hi, n;
      logic is_rd, is_wr;
      is_rd = (t == e_cce_mem_rd) || (t == e_cce_mem_uc_rd);
      is_wr = (t == e_cce_mem_wr) || (t == e_cce_mem_uc_wr);
      n = (is_rd || is_wr) ? ndw(s) : 1;
      cmd.header.msg_type       = t;
      cmd.header.addr           = a;
      cmd.header.size           = bp_mem_msg_size_e'(s);
      cmd.header.payload.lce_id = 4'(vectors + 3);
      cmd.header.payload.way_id = 3'd5;
      cmd.data                  = d;
      e.header = cmd.header;
      e.data   = is_rd ? mdl_read(a, s) : '0;
      if (is_wr) mdl_write(a, s, d);
      sb.push_back(e);
      cv  = 1'b1;
      cyc = 0;
      while (!rdy && cyc < 50) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      cv = 1'b0;
      cmd.data = ~d;
      cmd.header.addr = ~a;
      cyc = 0;
      rdy_hi = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (rdy) rdy_hi++;
      end while (!rv && cyc < 300);
      check({tag, " latency"}, MW'(cyc), MW'((sel ? 4 : 0) + n + 1));
      check({tag, " ready while busy"}, MW'(rdy_hi), '0);
      e = sb.pop_front();
      last_resp = resp;
      check({tag, " resp"}, resp, e);
      if (hold > 0) begin
         first  = resp;
         cv     = 1'b1;
         cyc    = 0;
         rdy_hi = 0;
         repeat (hold) begin
            @(posedge clk); #1;
            if (resp !== first || !rv) cyc++;
            if (rdy) rdy_hi++;
         end
         check({tag, " resp stable"}, MW'(cyc), '0);
         check({tag, " pending cmd held off"}, MW'(rdy_hi), '0);
         cv = 1'b0;
      end
      yv = 1'b1;
      @(posedge clk); #1;
      yv = 1'b0;
      check({tag, " ready after yumi"}, MW'(rdy), MW'(1));
      check({tag, " valid after yumi"}, MW'(rv), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [511:0] d;
      rst_n = 1'b0; cv = 1'b0; yv = 1'b0; sel = 1'b0; cmd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", MW'(rdy0), '0);
      check("reset valid", MW'(rv0), '0);
      check("reset resp", resp0, '0);
      check("reset ready lat", MW'(rdy1), '0);
      rst_n = 1'b1;
      #1 check("ready before first clock", MW'(rdy0), '0);
      @(posedge clk); #1;
      check("ready after release", MW'(rdy0), MW'(1));
      check("ready after release lat", MW'(rdy1), MW'(1));

      // 8B uncached write then read-back
      xact(e_cce_mem_uc_wr, 40'h00_8000_0008, 3'd3, {448'h5a5a, 64'hDEAD_BEEF_0123_4567}, 0, "uc wr8");
      xact(e_cce_mem_uc_rd, 40'h00_8000_0008, 3'd3, '1, 0, "uc rd8");
      check("uc rd8 data", MW'(last_resp.data), MW'(64'hDEAD_BEEF_0123_4567));

      // Byte write merges into an existing dword
      xact(e_cce_mem_wr, 40'h00_8000_0010, 3'd3, 512'h1122_3344_5566_7788, 0, "wr8 base");
      xact(e_cce_mem_wr, 40'h00_8000_0013, 3'd0, {448'h77, 64'hFFFF_FFFF_FFFF_FFAB}, 0, "wr1");
      xact(e_cce_mem_rd, 40'h00_8000_0010, 3'd3, '0, 0, "rd8 merged");
      check("rd8 merged data", MW'(last_resp.data), MW'(64'h1122_3344_AB66_7788));
      xact(e_cce_mem_rd, 40'h00_8000_0012, 3'd1, '0, 0, "rd2");
      check("rd2 data", MW'(last_resp.data), MW'(16'hAB66));

      // Critical-dword-first 64B read
      for (int j = 0; j < 8; j++)
         xact(e_cce_mem_uc_wr, 40'h00_8000_0000 + 40'(j * 8), 3'd3, 512'(j), 0, "preload");
      xact(e_cce_mem_rd, 40'h00_8000_0030, 3'd6, '0, 0, "rd64 wrap");
      check("rd64 order", MW'(last_resp.data),
            MW'({64'd5, 64'd4, 64'd3, 64'd2, 64'd1, 64'd0, 64'd7, 64'd6}));

      // 64B write then wrapped 32B read, response held for 20 cycles with a pending command
      for (int j = 0; j < 8; j++) d[j*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(j);
      xact(e_cce_mem_wr, 40'h00_8000_0040, 3'd6, d, 0, "wr64");
      xact(e_cce_mem_rd, 40'h00_8000_0050, 3'd5, '0, 20, "rd32 hold");
      check("rd32 order", MW'(last_resp.data),
            MW'({64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0000,
                 64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0002}));

      // Non-memory type: one cycle, zero data
      xact(e_cce_mem_pre, 40'h00_8000_0000, 3'd6, '1, 0, "pre");

      // latency_p = 4 instance
      sel = 1'b1;
      for (int j = 0; j < 8; j++) d[j*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(j);
      xact(e_cce_mem_wr, 40'h00_8004_0000, 3'd6, d, 0, "lat wr64");
      xact(e_cce_mem_rd, 40'h00_8004_0008, 3'd3, '0, 0, "lat rd8");
      sel = 1'b0;

      // Reset three cycles into a 64B write
      for (int j = 0; j < 8; j++) d[j*64 +: 64] = 64'h100 + 64'(j);
      cmd.header.msg_type = e_cce_mem_wr;
      cmd.header.addr     = 40'h00_8000_0000;
      cmd.header.size     = e_mem_msg_size_64;
      cmd.data            = d;
      cv = 1'b1;
      @(posedge clk); #1;
      cv = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort valid", MW'(rv0), '0);
      check("abort ready", MW'(rdy0), '0);
      check("abort resp", resp0, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 check("abort ready before clock", MW'(rdy0), '0);
      @(posedge clk); #1;
      check("abort ready after clock", MW'(rdy0), MW'(1));
      for (int j = 0; j < 3; j++) mdl[j] = d[j*64 +: 64];
      xact(e_cce_mem_rd, 40'h00_8000_0000, 3'd6, '0, 0, "rd after abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
